// File: rtl/accum_delta_decoder.sv
// Recovers per-sample increments from a stream of modular running sums.
// A two-entry output FIFO decouples the input handshake from consumer backpressure.
module accum_delta_decoder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_wrap,
    input  logic             out_ready,
    output logic [7:0]       out_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    fifo_state_e      state_q, state_d;
    logic [WIDTH:0]   head_q, head_d;
    logic [WIDTH:0]   tail_q, tail_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [7:0]       count_q, count_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   diff;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL) | out_ready;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Extended subtract: the top bit is the borrow, i.e. the wrap flag.
    assign base      = restart ? '0 : prev_q;
    assign diff      = {1'b0, in_data} - {1'b0, base};

    assign out_data  = out_valid ? head_q[WIDTH-1:0] : '0;
    assign out_wrap  = out_valid ? head_q[WIDTH] : 1'b0;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        prev_d  = push ? in_data : base;
        count_d = pop ? count_q + 8'd1 : count_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = diff;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = diff;
                end else if (push) begin
                    tail_d  = diff;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = diff;
                end else if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            prev_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            prev_q  <= prev_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_accum_delta_decoder.sv
// Directed bench for accum_delta_decoder: a queue-based model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_accum_delta_decoder;

    logic       clk;
    logic       reset;
    logic       restart;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_wrap;
    logic       out_ready;
    logic [7:0] out_count;

    int nChecks = 0;
    int nFails  = 0;

    accum_delta_decoder #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_wrap  (out_wrap),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a queue of {wrap, delta} entries, the previous sum and a delivery counter.
    logic [4:0] mq[$];
    int         mPrev   = 0;
    int         mCount  = 0;
    int         mBase;
    int         mDelta;
    bit         mPush;
    bit         mPop;
    bit         started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            mPrev   = 0;
            mCount  = 0;
            started = 1'b1;
        end else if (started) begin
            mPop   = (mq.size() > 0) && out_ready;
            mPush  = in_valid && ((mq.size() < 2) || out_ready);
            mBase  = restart ? 0 : mPrev;
            mDelta = (int'(in_data) - mBase + 16) % 16;
            if (mPop) begin
                void'(mq.pop_front());
                mCount = (mCount + 1) % 256;
            end
            if (mPush) begin
                mq.push_back({(int'(in_data) < mBase) ? 1'b1 : 1'b0, 4'(mDelta)});
                mPrev = int'(in_data);
            end else begin
                mPrev = mBase;
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            checkOutput("model_in_ready", int'(in_ready), int'((mq.size() < 2) || out_ready));
            checkOutput("model_out_valid", int'(out_valid), int'(mq.size() != 0));
            checkOutput("model_out_count", int'(out_count), mCount);
            if (mq.size() != 0) begin
                checkOutput("model_out_data", int'(out_data), int'(mq[0][3:0]));
                checkOutput("model_out_wrap", int'(out_wrap), int'(mq[0][4]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveInputs(input bit v, input int d, input bit rs, input bit ordy);
        in_valid  = v;
        in_data   = 4'(d);
        restart   = rs;
        out_ready = ordy;
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit rs, input bit ordy);
        driveInputs(v, d, rs, ordy);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        driveInputs(0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_count", int'(out_count), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_out_wrap", int'(out_wrap), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);

        // Plain running sums, consumer always ready.
        applyStimulus(1, 0, 0, 1); checkOutput("t1_delta0", int'(out_data), 0);
        checkOutput("t1_valid0", int'(out_valid), 1);
        applyStimulus(1, 1, 0, 1); checkOutput("t1_delta1", int'(out_data), 1);
        applyStimulus(1, 3, 0, 1); checkOutput("t1_delta2", int'(out_data), 2);
        applyStimulus(1, 6, 0, 1); checkOutput("t1_delta3", int'(out_data), 3);
        checkOutput("t1_wrap3", int'(out_wrap), 0);
        applyStimulus(0, 0, 0, 1); checkOutput("t1_count", int'(out_count), 4);
        checkOutput("t1_drained", int'(out_valid), 0);

        // Modular wrap of the running sum.
        applyStimulus(1, 10, 1, 1); checkOutput("t2_delta10", int'(out_data), 10);
        checkOutput("t2_wrap10", int'(out_wrap), 0);
        applyStimulus(1, 14, 0, 1); checkOutput("t2_delta14", int'(out_data), 4);
        checkOutput("t2_wrap14", int'(out_wrap), 0);
        applyStimulus(1, 2, 0, 1); checkOutput("t2_delta2", int'(out_data), 4);
        checkOutput("t2_wrap2", int'(out_wrap), 1);
        applyStimulus(1, 2, 0, 1); checkOutput("t2_delta2b", int'(out_data), 0);
        checkOutput("t2_wrap2b", int'(out_wrap), 0);
        applyStimulus(0, 0, 0, 1);

        // Backpressure fills the FIFO and stalls the input.
        applyStimulus(0, 0, 1, 1);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 0);
        applyStimulus(1, 3, 0, 0);
        checkOutput("t3_in_ready_full", int'(in_ready), 0);
        checkOutput("t3_hold_data", int'(out_data), 1);
        checkOutput("t3_hold_valid", int'(out_valid), 1);
        applyStimulus(1, 3, 0, 1); checkOutput("t3_second", int'(out_data), 1);
        applyStimulus(0, 0, 0, 1); checkOutput("t3_third", int'(out_data), 1);
        checkOutput("t3_third_valid", int'(out_valid), 1);
        applyStimulus(0, 0, 0, 1); checkOutput("t3_count", int'(out_count), 11);
        checkOutput("t3_drained", int'(out_valid), 0);

        // Simultaneous push and pop while full.
        applyStimulus(1, 4, 0, 0);
        applyStimulus(1, 6, 0, 0);
        driveInputs(1, 9, 0, 1);
        #1;
        checkOutput("t4_in_ready_full_pop", int'(in_ready), 1);
        tick();
        checkOutput("t4_head", int'(out_data), 2);
        applyStimulus(0, 0, 0, 1); checkOutput("t4_next", int'(out_data), 3);
        checkOutput("t4_next_valid", int'(out_valid), 1);
        applyStimulus(0, 0, 0, 1); checkOutput("t4_count", int'(out_count), 14);

        // Restart coinciding with an accepted sample.
        applyStimulus(1, 5, 0, 1); checkOutput("t5_delta5", int'(out_data), 12);
        checkOutput("t5_wrap5", int'(out_wrap), 1);
        applyStimulus(1, 9, 0, 1); checkOutput("t5_delta9", int'(out_data), 4);
        applyStimulus(1, 4, 1, 1); checkOutput("t5_restart_delta", int'(out_data), 4);
        checkOutput("t5_restart_wrap", int'(out_wrap), 0);
        applyStimulus(1, 7, 0, 1); checkOutput("t5_after_restart", int'(out_data), 3);
        applyStimulus(0, 0, 0, 1); checkOutput("t5_count", int'(out_count), 18);

        // Reset with entries queued.
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 2, 0, 0);
        checkOutput("t6_queued_valid", int'(out_valid), 1);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("t6_reset_valid", int'(out_valid), 0);
        checkOutput("t6_reset_count", int'(out_count), 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t6_nothing_emitted", int'(out_valid), 0);
        applyStimulus(1, 3, 0, 1); checkOutput("t6_delta3", int'(out_data), 3);
        checkOutput("t6_wrap3", int'(out_wrap), 0);
        applyStimulus(0, 0, 0, 1); checkOutput("t6_count", int'(out_count), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
